// File: rtl/rr_arbiter8_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_pkg
//   Shared definitions for the 8-way round-robin arbiter: requester count,
//   grant code width and the FSM state encoding.
// ---------------------------------------------------------------------------
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int CW    = $clog2(N_REQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
//   Combinational round-robin picker. Finds the first set request at or
//   after ptr, wrapping modulo 8.
// Ports
//   req      in   8  request vector, bit i = requester i
//   ptr      in   3  highest-priority index
//   win_code out  3  index of the winning requester (valid when any=1)
//   any      out  1  at least one request present
// ---------------------------------------------------------------------------
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [CW-1:0]    ptr,
    output logic [CW-1:0]    win_code,
    output logic             any
);

    logic [CW-1:0] offset;

    // Scanning the rotated vector from the top down leaves the lowest set
    // offset in place, i.e. a fixed-priority encoder with bit 0 highest.
    // The 3-bit index arithmetic wraps naturally, which does the rotation.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + CW'(i)]) begin
                offset = CW'(i);
            end
        end
    end

    assign win_code = ptr + offset;
    assign any      = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
//   Round-robin arbiter sharing one downstream resource among 8 requesters.
//   The requester just served drops to lowest priority; a hold timeout
//   revokes a grant held for MAX_HOLD cycles (MAX_HOLD=0 disables it).
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   en        in   1  arbitration enable, gates new grants only
//   req       in   8  request vector
//   done      in   1  current holder finished (single-cycle pulse)
//   gnt       out  8  registered one-hot grant
//   gnt_code  out  3  binary index of the granted requester
//   gnt_valid out  1  |gnt
//   idle      out  1  FSM in IDLE and no grant outstanding
//   timeout   out  1  one-cycle pulse when a grant is revoked by MAX_HOLD
// ---------------------------------------------------------------------------
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [CW-1:0]    gnt_code,
    output logic             gnt_valid,
    output logic             idle,
    output logic             timeout
);

    // A zero-width counter is illegal, so keep one bit when the timeout is off.
    localparam int            HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]    code_q, code_d;
    logic             timeout_q, timeout_d;

    logic [CW-1:0]    win_code;
    logic             any_req;
    logic             rel_done, rel_drop, rel_tmo;

    rr_pick8 u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .win_code (win_code),
        .any      (any_req)
    );

    // Release causes, only acted on in BUSY.
    assign rel_done = done;
    assign rel_drop = ~req[code_q];
    assign rel_tmo  = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        code_d    = code_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && any_req) begin
                    state_d = ST_BUSY;
                    gnt_d   = N_REQ'(1) << win_code;
                    code_d  = win_code;
                    hold_d  = HW'(1);
                end
            end
            ST_BUSY: begin
                if (rel_done || rel_drop || rel_tmo) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    code_d    = '0;
                    hold_d    = '0;
                    // Served requester drops to lowest priority; 7 wraps to 0.
                    ptr_d     = code_q + CW'(1);
                    // Pulse only when the hold limit alone forced the release.
                    timeout_d = rel_tmo && !rel_done && !rel_drop;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LIM)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            code_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            code_q    <= code_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_code  = code_q;
    assign gnt_valid = |gnt_q;
    assign idle      = (state_q == ST_IDLE) && !gnt_valid;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
//   Directed bench for rr_arbiter8 built with MAX_HOLD=4 so the hold timeout
//   is reachable in a few cycles. Outputs are sampled 1 time unit after the
//   rising edge; inputs change at the same point, well before the next edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_code;
    logic       gnt_valid;
    logic       idle;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_code  (gnt_code),
        .gnt_valid (gnt_valid),
        .idle      (idle),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Expected {gnt, gnt_code, gnt_valid, idle, timeout}.
    function automatic logic [13:0] expv(input logic v, input logic [2:0] c, input logic to);
        logic [7:0] g;
        g = v ? (8'd1 << c) : 8'd0;
        return {g, (v ? c : 3'd0), v, ~v, to};
    endfunction

    task automatic check(input string tag, input logic [13:0] exp_v);
        logic [13:0] obs;
        obs = {gnt, gnt_code, gnt_valid, idle, timeout};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed gnt=%b code=%0d valid=%b idle=%b timeout=%b expected gnt=%b code=%0d valid=%b idle=%b timeout=%b",
                   tag, obs[13:6], obs[5:3], obs[2], obs[1], obs[0],
                   exp_v[13:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_assert", expv(1'b0, 3'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #3;
        check("reset_state", expv(1'b0, 3'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1) single requester, latency 1
        en  = 1'b1;
        req = 8'b0000_0001;
        tick();
        check("t1_grant", expv(1'b1, 3'd0, 1'b0));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t1_release", expv(1'b0, 3'd0, 1'b0));

        // 2) all requesting, done 2 cycles after each grant: 0..7,0 with bubbles
        apply_reset();
        req = 8'hFF;
        for (int c = 0; c < 9; c++) begin
            tick();
            check("t2_grant", expv(1'b1, 3'(c % 8), 1'b0));
            tick();
            check("t2_hold", expv(1'b1, 3'(c % 8), 1'b0));
            done = 1'b1;
            tick();
            done = 1'b0;
            check("t2_bubble", expv(1'b0, 3'd0, 1'b0));
        end

        // 3) hold timeout with requesters 3 and 5 (ptr is 1 here)
        req = 8'b0010_1000;
        tick();
        check("t3_grant3", expv(1'b1, 3'd3, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold3", expv(1'b1, 3'd3, 1'b0));
        end
        tick();
        check("t3_timeout3", expv(1'b0, 3'd0, 1'b1));
        tick();
        check("t3_grant5", expv(1'b1, 3'd5, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold5", expv(1'b1, 3'd5, 1'b0));
        end
        tick();
        check("t3_timeout5", expv(1'b0, 3'd0, 1'b1));
        tick();
        check("t3_ptr6", expv(1'b1, 3'd3, 1'b0));
        req = 8'h00;
        tick();
        check("t3_drop", expv(1'b0, 3'd0, 1'b0));

        // 4) enable gating
        apply_reset();
        en  = 1'b0;
        req = 8'h81;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_en_off", expv(1'b0, 3'd0, 1'b0));
        end
        en = 1'b1;
        tick();
        check("t4_grant0", expv(1'b1, 3'd0, 1'b0));
        en = 1'b0;
        tick();
        check("t4_en_low_hold", expv(1'b1, 3'd0, 1'b0));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t4_release", expv(1'b0, 3'd0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t4_no_regrant", expv(1'b0, 3'd0, 1'b0));
        end
        en = 1'b1;
        tick();
        check("t4_regrant7", expv(1'b1, 3'd7, 1'b0));

        // 5) async reset mid-grant on code 6
        done = 1'b1;
        req  = 8'b0100_0000;
        tick();
        done = 1'b0;
        check("t5_release7", expv(1'b0, 3'd0, 1'b0));
        tick();
        check("t5_grant6", expv(1'b1, 3'd6, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async", expv(1'b0, 3'd0, 1'b0));
        req = 8'b0100_0001;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t5_after_reset", expv(1'b1, 3'd0, 1'b0));

        // 6) request drop, done+drop, done+timeout
        req = 8'b0000_0100;
        tick();
        check("t6_drop0", expv(1'b0, 3'd0, 1'b0));
        tick();
        check("t6_grant2", expv(1'b1, 3'd2, 1'b0));
        req = 8'b0000_1011;
        tick();
        check("t6_drop2", expv(1'b0, 3'd0, 1'b0));
        tick();
        check("t6_ptr3", expv(1'b1, 3'd3, 1'b0));
        req  = 8'b0000_0001;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t6_done_drop", expv(1'b0, 3'd0, 1'b0));
        tick();
        check("t6_single_release", expv(1'b1, 3'd0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_hold0", expv(1'b1, 3'd0, 1'b0));
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t6_done_tmo", expv(1'b0, 3'd0, 1'b0));
        tick();
        check("t6_regrant0", expv(1'b1, 3'd0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
